// File: rtl/padcfg_ctrl.sv
// Pad configuration controller: bus-visible shadow config, committed active config,
// and a pad-hold sequencer covering power-up hold, default init and post-commit settle.
module padcfg_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  DEFAULT_CFG   = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [5:0]  addr_i,
  input  logic [7:0]  wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [7:0]  rdata_o,
  output logic        err_o,
  output logic [71:0] we_cfg_o,
  output logic [71:0] no_cfg_o,
  output logic [71:0] ea_cfg_o,
  output logic [71:0] so_cfg_o,
  output logic        pad_hold_o,
  output logic        ready_o
);

  localparam int unsigned NUM_PADS  = 36;
  localparam int unsigned LAST_PAD  = NUM_PADS - 1;
  localparam logic [5:0]  CMD_ADDR  = 6'd63;
  localparam int unsigned TIMER_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX   = (TIMER_MAX > NUM_PADS) ? TIMER_MAX : NUM_PADS;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_INIT   = 2'd1,
    ST_READY  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     dirty;
  logic [NUM_PADS-1:0][7:0] shadow;
  logic [NUM_PADS-1:0][7:0] active;
  logic [5:0]               pad_idx;

  assign pad_idx = 6'(cnt);

  // Requests are only accepted while idle and ready; elsewhere the requester keeps holding.
  assign gnt_o = req_i & (state == ST_READY);

  // Active config is flopped storage, so the side buses are registered outputs.
  assign we_cfg_o = active[8:0];
  assign no_cfg_o = active[17:9];
  assign ea_cfg_o = active[26:18];
  assign so_cfg_o = active[35:27];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_HOLD;
      cnt        <= '0;
      dirty      <= 1'b0;
      shadow     <= '0;
      active     <= '0;
      pad_hold_o <= 1'b1;
      ready_o    <= 1'b0;
      rvalid_o   <= 1'b0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      case (state)
        ST_HOLD: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state <= ST_INIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_INIT: begin
          shadow[pad_idx] <= DEFAULT_CFG;
          active[pad_idx] <= DEFAULT_CFG;
          if (cnt == CNT_W'(LAST_PAD)) begin
            state      <= ST_READY;
            cnt        <= '0;
            ready_o    <= 1'b1;
            pad_hold_o <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_READY: begin
          if (req_i) begin
            rvalid_o <= 1'b1;
            if (addr_i < 6'(NUM_PADS)) begin
              if (we_i) begin
                shadow[addr_i] <= wdata_i;
                dirty          <= 1'b1;
              end else begin
                rdata_o <= shadow[addr_i];
              end
            end else if (addr_i == CMD_ADDR) begin
              if (we_i) begin
                active     <= shadow;
                dirty      <= 1'b0;
                state      <= ST_SETTLE;
                cnt        <= '0;
                pad_hold_o <= 1'b1;
              end else begin
                rdata_o <= {6'b0, ready_o, dirty};
              end
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state      <= ST_READY;
            cnt        <= '0;
            pad_hold_o <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_padcfg_ctrl.sv
// Randomised scoreboard bench for padcfg_ctrl against a byte-array model of the
// shadow/active config, dirty flag and settle window.
module tb_padcfg_ctrl;

  localparam int         HOLD   = 16;
  localparam int         SETTLE = 4;
  localparam logic [7:0] DEF    = 8'hA5;
  localparam int         NPADS  = 36;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [5:0]  addr_i;
  logic [7:0]  wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [7:0]  rdata_o;
  logic        err_o;
  logic [71:0] we_cfg_o;
  logic [71:0] no_cfg_o;
  logic [71:0] ea_cfg_o;
  logic [71:0] so_cfg_o;
  logic        pad_hold_o;
  logic        ready_o;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } resp_t;

  resp_t      exp_q[$];
  resp_t      mon_e;
  logic [7:0] sh_m [NPADS];
  logic [7:0] ac_m [NPADS];
  logic       dirty_m;
  int         settle_left;
  int         total = 0;
  int         bad   = 0;

  always #5 clk_i = ~clk_i;

  padcfg_ctrl #(
    .HOLD_CYCLES  (HOLD),
    .SETTLE_CYCLES(SETTLE),
    .DEFAULT_CFG  (DEF)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .we_cfg_o  (we_cfg_o),
    .no_cfg_o  (no_cfg_o),
    .ea_cfg_o  (ea_cfg_o),
    .so_cfg_o  (so_cfg_o),
    .pad_hold_o(pad_hold_o),
    .ready_o   (ready_o)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] side_cfg(input int s);
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[8*k +: 8] = ac_m[s*9 + k];
    return v;
  endfunction

  task automatic check_cfg(input string tag);
    chk({tag, "_we_cfg"}, we_cfg_o, side_cfg(0));
    chk({tag, "_no_cfg"}, no_cfg_o, side_cfg(1));
    chk({tag, "_ea_cfg"}, ea_cfg_o, side_cfg(2));
    chk({tag, "_so_cfg"}, so_cfg_o, side_cfg(3));
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rvalid_unexpected: got rvalid=1 expected none at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rdata", 72'(rdata_o), 72'(mon_e.rdata));
        chk("err", 72'(err_o), 72'(mon_e.err));
      end
    end
  end

  task automatic model_access(input logic we, input logic [5:0] addr, input logic [7:0] data,
                              output resp_t r, output logic commit);
    r      = '0;
    commit = 1'b0;
    if (addr < 6'd36) begin
      if (we) begin
        sh_m[addr] = data;
        dirty_m    = 1'b1;
      end else begin
        r.rdata = sh_m[addr];
      end
    end else if (addr == 6'd63) begin
      if (we) begin
        commit  = 1'b1;
        dirty_m = 1'b0;
      end else begin
        r.rdata = {6'b0, 1'b1, dirty_m};
      end
    end else begin
      r.err = 1'b1;
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the response cycle with req still high.
  task automatic do_req(input logic we, input logic [5:0] addr, input logic [7:0] data);
    resp_t r;
    logic  commit;
    int    waited;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = data;
    waited  = 0;
    #1;
    while (gnt_o !== 1'b1) begin
      chk("gnt_blocked", 72'(gnt_o), 72'(settle_left == 0));
      chk("hold_blocked", 72'(pad_hold_o), 72'(settle_left != 0));
      if (settle_left > 0) settle_left--;
      waited++;
      if (waited > 50) begin
        total++;
        bad++;
        $display("FAIL grant_timeout: got no grant after %0d cycles expected grant", waited);
        req_i = 1'b0;
        return;
      end
      @(negedge clk_i);
      #1;
    end
    chk("settle_left_at_grant", 72'(settle_left), 72'(0));
    chk("hold_at_grant", 72'(pad_hold_o), 72'(0));
    chk("ready_at_grant", 72'(ready_o), 72'(1));
    settle_left = 0;
    model_access(we, addr, data, r, commit);
    exp_q.push_back(r);
    @(posedge clk_i);
    if (commit) begin
      ac_m        = sh_m;
      settle_left = SETTLE;
    end
    @(negedge clk_i);
    chk("rvalid_timing", 72'(rvalid_o), 72'(1));
    chk("hold_after_access", 72'(pad_hold_o), 72'(commit));
    check_cfg("access");
  endtask

  task automatic idle(input int n);
    req_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("idle_gnt", 72'(gnt_o), 72'(0));
      chk("idle_hold", 72'(pad_hold_o), 72'(settle_left != 0));
      if (settle_left > 0) settle_left--;
      @(negedge clk_i);
    end
  endtask

  // Assert reset now, check reset values, then run HOLD+INIT (optionally stopping mid-INIT).
  task automatic init_seq(input int abort_at);
    rst_i = 1'b1;
    req_i = 1'b1;
    we_i  = 1'b0;
    addr_i = 6'd63;
    #1;
    exp_q.delete();
    settle_left = 0;
    dirty_m     = 1'b0;
    for (int p = 0; p < NPADS; p++) begin
      sh_m[p] = 8'h00;
      ac_m[p] = 8'h00;
    end
    chk("rst_gnt", 72'(gnt_o), 72'(0));
    chk("rst_hold", 72'(pad_hold_o), 72'(1));
    chk("rst_ready", 72'(ready_o), 72'(0));
    chk("rst_rvalid", 72'(rvalid_o), 72'(0));
    chk("rst_rdata", 72'(rdata_o), 72'(0));
    chk("rst_err", 72'(err_o), 72'(0));
    check_cfg("rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < HOLD + NPADS; i++) begin
      #1;
      chk("init_hold", 72'(pad_hold_o), 72'(1));
      chk("init_ready", 72'(ready_o), 72'(0));
      chk("init_gnt", 72'(gnt_o), 72'(0));
      if (i == abort_at) begin
        for (int p = 0; p < NPADS; p++) ac_m[p] = (p <= i - HOLD - 1) ? DEF : 8'h00;
        check_cfg("partial_init");
        return;
      end
      @(negedge clk_i);
    end
    req_i = 1'b0;
    #1;
    for (int p = 0; p < NPADS; p++) begin
      sh_m[p] = DEF;
      ac_m[p] = DEF;
    end
    chk("ready_rise", 72'(ready_o), 72'(1));
    chk("ready_hold", 72'(pad_hold_o), 72'(0));
    check_cfg("init_done");
    @(negedge clk_i);
  endtask

  task automatic random_ops(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      do_req(1'b1, 6'($urandom_range(0, 35)), 8'($urandom));
      else if (r < 75) do_req(1'b0, 6'($urandom_range(0, 35)), 8'($urandom));
      else if (r < 82) do_req(1'b0, 6'd63, 8'($urandom));
      else if (r < 87) do_req(1'b1, 6'd63, 8'($urandom));
      else if (r < 95) do_req(1'($urandom), 6'($urandom_range(36, 62)), 8'($urandom));
      else             idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    rst_i   = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    #3;
    init_seq(-1);

    do_req(1'b0, 6'd63, 8'h00);
    do_req(1'b1, 6'd9, 8'h3C);
    do_req(1'b0, 6'd9, 8'h00);
    idle(1);
    do_req(1'b0, 6'd63, 8'h00);
    do_req(1'b1, 6'd63, 8'h00);
    chk("commit_no_pad0", 72'(no_cfg_o[7:0]), 72'(8'h3C));
    do_req(1'b0, 6'd63, 8'h00);
    do_req(1'b0, 6'd40, 8'h00);
    do_req(1'b1, 6'd50, 8'hFF);
    idle(2);

    do_req(1'b1, 6'd0, 8'h11);
    do_req(1'b1, 6'd35, 8'h22);
    do_req(1'b1, 6'd27, 8'h33);
    idle(1);
    do_req(1'b1, 6'd63, 8'h00);
    idle(SETTLE + 1);
    chk("b2b_we0", 72'(we_cfg_o[7:0]), 72'(8'h11));
    chk("b2b_so8", 72'(so_cfg_o[71:64]), 72'(8'h22));
    chk("b2b_so0", 72'(so_cfg_o[7:0]), 72'(8'h33));
    do_req(1'b1, 6'd63, 8'h00);

    random_ops(300);

    do_req(1'b1, 6'd5, 8'h5A);
    do_req(1'b1, 6'd63, 8'h00);
    idle(1);
    init_seq(-1);
    init_seq(HOLD + 21);
    init_seq(-1);

    random_ops(200);
    idle(SETTLE + 2);
    chk("queue_drained", 72'(exp_q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
